// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator driven by the SPI register map.
//
// A shared prescaler divides clk into PWM steps; a shared phase counter runs
// 0..254 so every period is 255 steps long. Each channel compares the phase
// against its own shadowed duty byte. The shadow copies of the duty bytes are
// reloaded only at a period wrap (or continuously while disabled), so register
// writes never cut a pulse short or add an extra edge mid-period.
//
// Ports:
//   clk          system clock (shared with the SPI slave)
//   rst          asynchronous, active-high reset
//   duty         flattened duty bytes, channel i is duty[8*i +: 8]
//   prescale     one PWM step every prescale+1 clk cycles
//   ctrl         bit0 enable, bit1 invert output polarity, bits 7:2 unused
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse following each period wrap
//   frame_cnt    number of completed periods, modulo 256

module pwm_bank #(
    parameter int CHANNELS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS*8-1:0]   duty,
    input  logic [7:0]              prescale,
    input  logic [7:0]              ctrl,
    output logic [CHANNELS-1:0]     pwm_out,
    output logic                    period_tick,
    output logic [7:0]              frame_cnt
);

    localparam logic [7:0] PHASE_LAST = 8'd254;

    logic                  en;
    logic                  inv;
    logic [7:0]            presc_cnt;
    logic [7:0]            phase;
    logic [CHANNELS*8-1:0] duty_sh;
    logic                  step;
    logic                  wrap;
    logic                  unused_ctrl;

    assign en          = ctrl[0];
    assign inv         = ctrl[1];
    assign unused_ctrl = ^ctrl[7:2];

    // step/wrap are gated by enable, so a disable on a wrap cycle yields no
    // tick, no frame count and no shadow load from the wrap path.
    assign step = en && (presc_cnt == prescale);
    assign wrap = step && (phase == PHASE_LAST);

    // Prescaler: only an exact match resets it. If prescale drops below the
    // current count, the counter runs through 255 and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= 8'd0;
        end else if (!en || (presc_cnt == prescale)) begin
            presc_cnt <= 8'd0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 8'd0;
        end else if (!en || wrap) begin
            phase <= 8'd0;
        end else if (step) begin
            phase <= phase + 8'd1;
        end
    end

    // Shadow follows the input while disabled, so the first period after
    // enable uses the duty value present on the last disabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh <= '0;
        end else if (!en || wrap) begin
            duty_sh <= duty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (en) begin
                    pwm_out[i] <= (phase < duty_sh[8*i +: 8]) ^ inv;
                end else begin
                    pwm_out[i] <= inv;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_tick <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            period_tick <= wrap;
            if (wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed testbench for pwm_bank: a table of single-period measurements
// followed by hand-written multi-cycle sequences.

module tb_pwm_bank;

    localparam int CH = 8;

    logic            clk;
    logic            rst;
    logic [CH*8-1:0] duty;
    logic [7:0]      prescale;
    logic [7:0]      ctrl;
    logic [CH-1:0]   pwm_out;
    logic            period_tick;
    logic [7:0]      frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pwm_bank #(.CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .duty        (duty),
        .prescale    (prescale),
        .ctrl        (ctrl),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] presc;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] c;
        int         cycles;
        int         h0;
        int         h1;
        int         h2;
        int         ticks;
        int         frame;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset, load inputs with enable held low for one cycle so the shadow
    // captures the duty bytes, then apply the full ctrl value.
    task automatic prime(input logic [7:0] p, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] c);
        rst      = 1'b1;
        prescale = p;
        duty     = '0;
        duty[7:0]   = d0;
        duty[15:8]  = d1;
        duty[23:16] = d2;
        ctrl     = c & 8'hFE;
        cyc();
        rst = 1'b0;
        cyc();
        ctrl = c;
    endtask

    initial begin
        int h0, h1, h2, tk, rises, prev, cnt, t1, t2, t3, f1, f2, f3;

        vecs[0] = '{"basic",      8'd0, 8'h80, 8'h00, 8'hFF, 8'h01,  255, 128,   0,  255, 1, 1};
        vecs[1] = '{"presc3",     8'd3, 8'h01, 8'h00, 8'hFF, 8'h01, 1020,   4,   0, 1020, 1, 1};
        vecs[2] = '{"invert",     8'd0, 8'h40, 8'h00, 8'hFF, 8'h03,  255, 191, 255,    0, 1, 1};
        vecs[3] = '{"dis_inv",    8'd0, 8'h40, 8'h00, 8'hFF, 8'h02,  255, 255, 255,  255, 0, 0};
        vecs[4] = '{"dis",        8'd0, 8'h40, 8'h00, 8'hFF, 8'h00,  255,   0,   0,    0, 0, 0};
        vecs[5] = '{"presc1",     8'd1, 8'h7F, 8'h01, 8'hFE, 8'h01,  510, 254,   2,  508, 1, 1};
        vecs[6] = '{"ctrl_upper", 8'd0, 8'h03, 8'hFE, 8'h00, 8'hFD,  255,   3, 254,    0, 1, 1};

        rst = 1'b1; duty = '0; prescale = 8'd0; ctrl = 8'h00;
        #1;
        chk("reset_pwm",   int'(pwm_out),     0);
        chk("reset_tick",  int'(period_tick), 0);
        chk("reset_frame", int'(frame_cnt),   0);

        // Table: one full period per vector, counting high samples and ticks.
        for (int v = 0; v < 7; v++) begin
            prime(vecs[v].presc, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].c);
            h0 = 0; h1 = 0; h2 = 0; tk = 0;
            for (int k = 0; k < vecs[v].cycles; k++) begin
                cyc();
                h0 += int'(pwm_out[0]);
                h1 += int'(pwm_out[1]);
                h2 += int'(pwm_out[2]);
                tk += int'(period_tick);
            end
            chk({vecs[v].name, "_high0"}, h0, vecs[v].h0);
            chk({vecs[v].name, "_high1"}, h1, vecs[v].h1);
            chk({vecs[v].name, "_high2"}, h2, vecs[v].h2);
            chk({vecs[v].name, "_ticks"}, tk, vecs[v].ticks);
            chk({vecs[v].name, "_frame"}, int'(frame_cnt), vecs[v].frame);
        end

        // Prescale 3: tick spacing and frame counter progression.
        prime(8'd3, 8'h01, 8'h00, 8'h00, 8'h01);
        t1 = -1; t2 = -1; t3 = -1; f1 = -1; f2 = -1; f3 = -1; cnt = 0;
        for (int k = 1; k <= 3100 && t3 < 0; k++) begin
            cyc();
            if (period_tick) begin
                cnt++;
                if (cnt == 1) begin t1 = k; f1 = int'(frame_cnt); end
                if (cnt == 2) begin t2 = k; f2 = int'(frame_cnt); end
                if (cnt == 3) begin t3 = k; f3 = int'(frame_cnt); end
            end
        end
        chk("presc_first_tick", t1, 1020);
        chk("presc_spacing12", t2 - t1, 1020);
        chk("presc_spacing23", t3 - t2, 1020);
        chk("presc_frame1", f1, 1);
        chk("presc_frame2", f2, 2);
        chk("presc_frame3", f3, 3);

        // Shadow: mid-period duty write is deferred to the next wrap.
        prime(8'd0, 8'h10, 8'h00, 8'h00, 8'h01);
        h0 = 0; h1 = 0; rises = 0; prev = 0; tk = 0;
        for (int k = 0; k < 255; k++) begin
            cyc();
            h0 += int'(pwm_out[0]);
            if (pwm_out[0] && prev == 0) rises++;
            prev = int'(pwm_out[0]);
            tk += int'(period_tick);
            if (k == 99) duty[7:0] = 8'hC0;
        end
        for (int k = 0; k < 255; k++) begin
            cyc();
            h1 += int'(pwm_out[0]);
            if (pwm_out[0] && prev == 0) rises++;
            prev = int'(pwm_out[0]);
            tk += int'(period_tick);
        end
        chk("shadow_old_high", h0, 16);
        chk("shadow_new_high", h1, 192);
        chk("shadow_rises", rises, 2);
        chk("shadow_ticks", tk, 2);

        // Invert, then disable mid-period with invert still set.
        prime(8'd0, 8'h40, 8'h00, 8'h00, 8'h03);
        for (int k = 0; k < 355; k++) cyc();
        chk("invdis_frame_before", int'(frame_cnt), 1);
        ctrl = 8'h02;
        cyc();
        chk("invdis_idle_level", int'(pwm_out), 255);
        tk = 0;
        for (int k = 0; k < 300; k++) begin
            cyc();
            tk += int'(period_tick);
        end
        chk("invdis_ticks", tk, 0);
        chk("invdis_frame_hold", int'(frame_cnt), 1);
        chk("invdis_idle_hold", int'(pwm_out), 255);

        // Frame counter wrap 255 -> 0.
        prime(8'd0, 8'h00, 8'h00, 8'h00, 8'h01);
        for (int k = 0; k < 255 * 255; k++) cyc();
        chk("wrap_frame255", int'(frame_cnt), 255);
        for (int k = 0; k < 255; k++) cyc();
        chk("wrap_frame0", int'(frame_cnt), 0);

        // Asynchronous reset between clock edges, at phase 77 of period 2.
        prime(8'd0, 8'hFF, 8'h00, 8'h00, 8'h01);
        for (int k = 0; k < 255 + 77; k++) cyc();
        chk("areset_pre_pwm", int'(pwm_out[0]), 1);
        chk("areset_pre_frame", int'(frame_cnt), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_pwm", int'(pwm_out), 0);
        chk("areset_frame", int'(frame_cnt), 0);
        chk("areset_tick", int'(period_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = -1;
        for (int k = 1; k <= 600 && cnt < 0; k++) begin
            cyc();
            if (period_tick) cnt = k;
        end
        chk("areset_first_tick", cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
